// File: rtl/riscv_pkg.sv
// Shared RISC-V fetch-side definitions: machine width, NOP encoding and the
// response record carried from the memory stage to the fetch stage.
package riscv_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0 -- returned in place of data on a faulting fetch
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] addr;
    logic            err;
  } fetch_rsp_t;

endpackage

// File: rtl/fetch_rsp_fifo.sv
// Small synchronous FIFO holding fetch responses. Async active-high reset,
// synchronous clear (flush) that wins over push and pop, occupancy output.
// Pointers wrap modulo DEPTH, so DEPTH need not be a power of two.
module fetch_rsp_fifo #(
  parameter int DEPTH = 3,
  parameter int WIDTH = 8,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic [CW-1:0]    count,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty   = (count == '0);
  assign do_push = push && !clear;
  assign do_pop  = pop && !clear && !empty;
  assign rd_data = mem[rd_ptr];

  // Pointer, occupancy and entry update; clear discards everything queued.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state is written with <= so every register samples pre-edge values;
    // blocking here would let later statements see half-updated state.
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      // NOTE: this few-entry store is reset so the head reads zero out of
      // reset; a large RAM (like the instruction array) is never reset.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wrap_inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= wrap_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/imem_fetch_responder.sv
// Instruction-memory side of the fetch interface. Word storage with a
// registered read (stage s1) feeding a response FIFO; request acceptance is
// credit based so the FIFO can never overflow while the fetch stage stalls.
module imem_fetch_responder
  import riscv_pkg::*;
#(
  parameter int    DEPTH     = 1024,
  parameter int    RSP_DEPTH = 3,
  parameter string INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_instr,
  output logic [31:0] rsp_addr,
  output logic        rsp_err,
  input  logic        flush,
  input  logic        load_we,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam logic [XLEN-3:0] DEPTH_WORDS = (XLEN - 2)'(DEPTH);

  logic [XLEN-1:0] mem [DEPTH];

  logic            req_err;
  logic            load_ok;
  logic [AW-1:0]   req_idx;
  logic [AW-1:0]   load_idx;
  logic            accept;

  logic            s1_valid;
  logic [XLEN-1:0] s1_addr;
  logic [XLEN-1:0] s1_rdata;
  logic            s1_err;
  fetch_rsp_t      s1_rsp;
  fetch_rsp_t      head_rsp;

  logic [CW-1:0]   fifo_count;
  logic            fifo_empty;

  // Address decode for the fetch and load ports.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    req_err  = 1'b0;
    load_ok  = 1'b0;
    req_idx  = req_addr[2+AW-1:2];
    load_idx = load_addr[2+AW-1:2];
    if (req_addr[1:0] != 2'b00 || req_addr[XLEN-1:2] >= DEPTH_WORDS) req_err = 1'b1;
    if (load_addr[1:0] == 2'b00 && load_addr[XLEN-1:2] < DEPTH_WORDS) load_ok = 1'b1;
  end

  // Credit check: everything in flight must fit in the FIFO, independent of rsp_ready.
  assign req_ready = (int'(fifo_count) + int'(s1_valid)) < RSP_DEPTH;
  assign accept    = req_valid && req_ready;

  // Program-load writes; bad addresses are dropped without complaint.
  always_ff @(posedge clk) begin
    if (load_we && load_ok) mem[load_idx] <= load_data;
  end

  // Registered read of the addressed word; reads the pre-write (old) contents.
  always_ff @(posedge clk) begin
    if (accept) s1_rdata <= mem[req_idx];
  end

  // s1 control: one entry that always drains into the FIFO on the next edge.
  // An accept in a flush cycle still loads, so the redirected fetch survives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_addr  <= '0;
      s1_err   <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_addr <= req_addr;
        s1_err  <= req_err;
      end
    end
  end

  assign s1_rsp = '{instr: (s1_err ? NOP_INSTR : s1_rdata), addr: s1_addr, err: s1_err};

  fetch_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH ($bits(fetch_rsp_t))
  ) u_rsp_fifo (
    .clk     (clk),
    .rst     (rst),
    .clear   (flush),
    .push    (s1_valid),
    .wr_data (s1_rsp),
    .pop     (rsp_valid && rsp_ready),
    .rd_data (head_rsp),
    .count   (fifo_count),
    .empty   (fifo_empty)
  );

  assign rsp_valid = !fifo_empty;
  assign rsp_instr = head_rsp.instr;
  assign rsp_addr  = head_rsp.addr;
  assign rsp_err   = head_rsp.err;

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Directed bench for imem_fetch_responder. Inputs change and outputs are
// sampled on the falling edge; the DUT acts on the rising edge between.
module tb_imem_fetch_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_instr;
  logic [31:0] rsp_addr;
  logic        rsp_err;
  logic        flush;
  logic        load_we;
  logic [31:0] load_addr;
  logic [31:0] load_data;

  int checks = 0;
  int errors = 0;
  int n_acc;

  localparam logic [31:0] NOP = 32'h0000_0013;

  imem_fetch_responder #(
    .DEPTH     (1024),
    .RSP_DEPTH (3),
    .INIT_FILE ("")
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_instr (rsp_instr),
    .rsp_addr  (rsp_addr),
    .rsp_err   (rsp_err),
    .flush     (flush),
    .load_we   (load_we),
    .load_addr (load_addr),
    .load_data (load_data)
  );

  always #5 clk = ~clk;

  // Image word stored at byte address a by the load phase below.
  function automatic logic [31:0] img(input logic [31:0] a);
    return 32'h1000_0000 + a;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic check_rsp(input string tag, input logic [31:0] instr,
                           input logic [31:0] addr, input logic err);
    check({tag, ".valid"}, 32'(rsp_valid), 32'd1);
    check({tag, ".instr"}, rsp_instr, instr);
    check({tag, ".addr"},  rsp_addr,  addr);
    check({tag, ".err"},   32'(rsp_err), 32'(err));
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    load_we   = 1'b1;
    load_addr = a;
    load_data = d;
    tick();
    load_we   = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_addr  = '0;
    rsp_ready = 1'b0;
    flush     = 1'b0;
    load_we   = 1'b0;
    load_addr = '0;
    load_data = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Reset state
    check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst.rsp_instr", rsp_instr, 32'd0);
    check("rst.rsp_addr",  rsp_addr,  32'd0);
    check("rst.rsp_err",   32'(rsp_err), 32'd0);
    check("rst.req_ready", 32'(req_ready), 32'd1);

    // Program image, plus a misaligned and an aliasing out-of-range load
    load(32'h00, img(32'h00));
    load(32'h04, img(32'h04));
    load(32'h08, img(32'h08));
    load(32'h10, img(32'h10));
    load(32'h20, img(32'h20));
    load(32'h24, img(32'h24));
    load(32'h28, img(32'h28));
    load(32'h40, img(32'h40));
    load(32'h12, 32'hBAD0_BAD0);
    load(32'h1020, 32'hBAD1_BAD1);

    // Back-to-back fetches with rsp_ready high
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_addr  = 32'h0;
    check("b2b.ready0", 32'(req_ready), 32'd1);
    tick();
    check("b2b.ready1", 32'(req_ready), 32'd1);
    check("b2b.lat1", 32'(rsp_valid), 32'd0);
    req_addr = 32'h4;
    tick();
    check("b2b.ready2", 32'(req_ready), 32'd1);
    check_rsp("b2b.A", img(32'h0), 32'h0, 1'b0);
    req_addr = 32'h8;
    tick();
    req_valid = 1'b0;
    check_rsp("b2b.B", img(32'h4), 32'h4, 1'b0);
    tick();
    check_rsp("b2b.C", img(32'h8), 32'h8, 1'b0);
    tick();
    check("b2b.drained", 32'(rsp_valid), 32'd0);

    // Backpressure: only RSP_DEPTH requests fit
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    n_acc     = 0;
    req_addr  = 32'h20;
    for (int i = 0; i < 6; i++) begin
      if (req_ready) n_acc++;
      tick();
      req_addr = 32'h20 + 32'(4 * n_acc);
    end
    req_valid = 1'b0;
    check("bp.accepted", 32'(n_acc), 32'd3);
    check("bp.ready_low", 32'(req_ready), 32'd0);
    check_rsp("bp.hold0", img(32'h20), 32'h20, 1'b0);
    tick();
    check_rsp("bp.hold1", img(32'h20), 32'h20, 1'b0);
    rsp_ready = 1'b1;
    tick();
    check_rsp("bp.d1", img(32'h24), 32'h24, 1'b0);
    tick();
    check_rsp("bp.d2", img(32'h28), 32'h28, 1'b0);
    tick();
    check("bp.empty", 32'(rsp_valid), 32'd0);
    check("bp.ready_back", 32'(req_ready), 32'd1);

    // Faulting fetches, then a good one
    req_valid = 1'b1;
    req_addr  = 32'h6;
    tick();
    req_addr = 32'h1000;
    tick();
    req_addr = 32'h0;
    check_rsp("err.misalign", NOP, 32'h6, 1'b1);
    tick();
    req_valid = 1'b0;
    check_rsp("err.range", NOP, 32'h1000, 1'b1);
    tick();
    check_rsp("err.ok", img(32'h0), 32'h0, 1'b0);
    tick();

    // Load and fetch the same word in one cycle: read-first
    load_we   = 1'b1;
    load_addr = 32'h10;
    load_data = 32'hDEAD_BEEF;
    req_valid = 1'b1;
    req_addr  = 32'h10;
    tick();
    load_we = 1'b0;
    tick();
    req_valid = 1'b0;
    check_rsp("rf.old", img(32'h10), 32'h10, 1'b0);
    tick();
    check_rsp("rf.new", 32'hDEAD_BEEF, 32'h10, 1'b0);
    tick();
    check("rf.empty", 32'(rsp_valid), 32'd0);

    // Flush with two responses queued and a redirect request in the same cycle
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_addr  = 32'h0;
    tick();
    req_addr = 32'h4;
    tick();
    req_valid = 1'b0;
    tick();
    check_rsp("fl.queued", img(32'h0), 32'h0, 1'b0);
    flush     = 1'b1;
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_addr  = 32'h40;
    check("fl.ready", 32'(req_ready), 32'd1);
    tick();
    flush     = 1'b0;
    req_valid = 1'b0;
    check("fl.cleared", 32'(rsp_valid), 32'd0);
    tick();
    check_rsp("fl.redirect", img(32'h40), 32'h40, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("fl.no_stale", 32'(rsp_valid), 32'd0);
    end

    // Asynchronous reset mid-stream
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_addr  = 32'h24;
    tick();
    req_addr = 32'h28;
    tick();
    req_valid = 1'b0;
    check_rsp("ar.before", img(32'h24), 32'h24, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("ar.rsp_valid", 32'(rsp_valid), 32'd0);
    check("ar.rsp_instr", rsp_instr, 32'd0);
    check("ar.rsp_addr",  rsp_addr,  32'd0);
    check("ar.rsp_err",   32'(rsp_err), 32'd0);
    tick();
    #2 rst = 1'b0;
    tick();
    check("ar.req_ready", 32'(req_ready), 32'd1);
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ar.no_stale", 32'(rsp_valid), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
